// File: rtl/uart_tx_feeder_if.sv
// Host-write and transmitter-handshake signals of the UART transmit feeder.
// The feeder takes the slave side; the host/transmitter environment takes master.
interface uart_tx_feeder_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  overflow;
  logic                  uart_enable;
  logic [DATA_W-1:0]     uart_data;
  logic                  uart_busy;
  logic                  tx_retry;

  modport master (
    output wr_en, wr_data, uart_busy,
    input  full, empty, fifo_count, overflow, uart_enable, uart_data, tx_retry
  );

  modport slave (
    input  wr_en, wr_data, uart_busy,
    output full, empty, fifo_count, overflow, uart_enable, uart_data, tx_retry
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO feeding a UART transmitter one byte per enable pulse;
// launches only when the transmitter is idle and re-launches unacknowledged bytes.
module uart_tx_feeder #(
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2       = 4,
  parameter int unsigned ACK_TIMEOUT      = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_feeder_if.slave bus
);
  localparam int unsigned          DEPTH    = 2 ** DEPTH_LOG2;
  localparam int unsigned          TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [DEPTH_LOG2:0]  CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE} state_e;

  logic [INPUT_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]         count_q, count_d;
  logic                        overflow_q, overflow_d;
  logic [INPUT_DATA_WIDTH-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        enable_q;
  logic                        retry_q, retry_d;
  state_e                      state_q, state_d;
  logic                        full_w, empty_w, wr_acc, pop;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    hold_d     = hold_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (bus.wr_en && full_w) overflow_d = 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    if (wr_acc && !pop) count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (pop && !wr_acc) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    retry_d = 1'b0;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (!empty_w && !bus.uart_busy) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.uart_busy) begin
          state_d = WAIT_IDLE;
        end else begin
          // compare the incremented count so the retry lands ACK_TIMEOUT cycles after the launch
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_LAST) begin
            state_d = LAUNCH;
            retry_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (!bus.uart_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
      tmo_q      <= '0;
      enable_q   <= 1'b0;
      retry_q    <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      enable_q   <= (state_d == LAUNCH);
      retry_q    <= retry_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.uart_enable = enable_q;
  assign bus.uart_data   = hold_q;
  assign bus.tx_retry    = retry_q;
endmodule
